water_supply_controller: RTL

WATER_SUPPLY_CONTROLLER -- requirements
Module: water_supply_controller

---
 rtl/water_supply_controller_if.sv | 24 ++
 rtl/water_supply_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/water_supply_controller_if.sv
// Tank-side bundle of the water supply controller: level probes and operator
// controls flow in, the debounced level and the pump/valve/status flags flow out.
interface water_supply_controller_if;
  logic       high;
  logic       mid;
  logic       low;
  logic       enable;
  logic       fault_clear;
  logic [1:0] level;
  logic       pump_on;
  logic       valve_open;
  logic       fault;
  logic       alarm_critical;

  modport master (
    output high, mid, low, enable, fault_clear,
    input  level, pump_on, valve_open, fault, alarm_critical
  );

  modport slave (
    input  high, mid, low, enable, fault_clear,
    output level, pump_on, valve_open, fault, alarm_critical
  );
endinterface

// File: rtl/water_supply_controller.sv
// Water tank pump controller: synchronizes and debounces three level probes,
// then runs an INIT/STANDBY/FILL/FAULT machine with a fill watchdog.
module water_supply_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FILL_TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  water_supply_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_STANDBY = 2'd1,
    S_FILL    = 2'd2,
    S_FAULT   = 2'd3
  } state_e;

  localparam logic [1:0]  LVL_CRIT  = 2'b00;
  localparam logic [1:0]  LVL_LOW   = 2'b01;
  localparam logic [1:0]  LVL_MID   = 2'b10;
  localparam logic [1:0]  LVL_HIGH  = 2'b11;
  // The reload edge is the first stable sample, so acceptance happens when the
  // counter shows DEBOUNCE_CYCLES-2 on the DEBOUNCE_CYCLES-th stable edge.
  localparam logic [7:0]  ACCEPT_AT = 8'(DEBOUNCE_CYCLES - 2);
  localparam logic [15:0] TIMEOUT   = 16'(FILL_TIMEOUT);

  // Reset asserts immediately and releases two edges later, so no state
  // register ever updates on the edge where reset_n rises.
  logic [1:0] rst_sync_q;
  logic       core_rst_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign core_rst_n = rst_sync_q[1];

  // Probe synchronizers run on the raw reset so sampling starts on the first
  // edge after release, ahead of the core coming out of reset.
  logic [2:0] probe_meta_q;
  logic [2:0] probe_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      probe_meta_q <= 3'b000;
      probe_sync_q <= 3'b000;
    end else begin
      probe_meta_q <= {bus.high, bus.mid, bus.low};
      probe_sync_q <= probe_meta_q;
    end
  end

  // Debounce: candidate pattern plus a stability counter.
  logic [2:0] cand_q,     cand_d;
  logic       cand_vld_q, cand_vld_d;
  logic [7:0] cnt_q,      cnt_d;
  logic       accept;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the if/case leaves it unassigned and infers a latch.
  always_comb begin
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    if (!cand_vld_q || (probe_sync_q != cand_q)) begin
      cand_d     = probe_sync_q;
      cand_vld_d = 1'b1;
      cnt_d      = 8'd0;
    end else if (cnt_q == ACCEPT_AT) begin
      accept = 1'b1;
      cnt_d  = cnt_q + 8'd1;
    end else if (cnt_q < ACCEPT_AT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  logic       pat_valid;
  logic [1:0] pat_level;

  always_comb begin
    pat_valid = 1'b1;
    pat_level = LVL_CRIT;
    case (cand_q)
      3'b000:  pat_level = LVL_CRIT;
      3'b001:  pat_level = LVL_LOW;
      3'b011:  pat_level = LVL_MID;
      3'b111:  pat_level = LVL_HIGH;
      default: pat_valid = 1'b0;
    endcase
  end

  logic [1:0] level_q,   level_d;
  logic       invalid_q, invalid_d;

  always_comb begin
    level_d   = level_q;
    invalid_d = invalid_q;
    if (accept) begin
      invalid_d = !pat_valid;
      if (pat_valid) level_d = pat_level;
    end
  end

  // Control state machine.
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: begin
        if (accept) state_d = pat_valid ? S_STANDBY : S_FAULT;
      end
      S_STANDBY: begin
        if (invalid_q)                         state_d = S_FAULT;
        else if (bus.enable && !level_q[1])    state_d = S_FILL;
      end
      S_FILL: begin
        // A full tank beats an expiring watchdog on the same cycle.
        if (invalid_q)                              state_d = S_FAULT;
        else if (level_q == LVL_HIGH || !bus.enable) state_d = S_STANDBY;
        else if (timer_q >= TIMEOUT)                state_d = S_FAULT;
      end
      S_FAULT: begin
        if (bus.fault_clear && !invalid_q) state_d = S_STANDBY;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    timer_d = 16'd0;
    if (state_q == S_FILL && state_d == S_FILL)
      timer_d = (timer_q >= TIMEOUT) ? timer_q : timer_q + 16'd1;
  end

  logic pump_on_q,    pump_on_d;
  logic valve_open_q, valve_open_d;
  logic fault_q,      fault_d;
  logic alarm_q,      alarm_d;

  always_comb begin
    pump_on_d    = (state_d == S_FILL);
    fault_d      = (state_d == S_FAULT);
    valve_open_d = ((state_d == S_STANDBY) || (state_d == S_FILL)) && (level_q != LVL_CRIT);
    alarm_d      = (level_q == LVL_CRIT) && (state_q != S_INIT);
  end

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      cand_q       <= 3'b000;
      cand_vld_q   <= 1'b0;
      cnt_q        <= 8'd0;
      level_q      <= LVL_CRIT;
      invalid_q    <= 1'b0;
      state_q      <= S_INIT;
      timer_q      <= 16'd0;
      pump_on_q    <= 1'b0;
      valve_open_q <= 1'b0;
      fault_q      <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      cand_vld_q   <= cand_vld_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      invalid_q    <= invalid_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      pump_on_q    <= pump_on_d;
      valve_open_q <= valve_open_d;
      fault_q      <= fault_d;
      alarm_q      <= alarm_d;
    end
  end

  assign bus.level          = level_q;
  assign bus.pump_on        = pump_on_q;
  assign bus.valve_open     = valve_open_q;
  assign bus.fault          = fault_q;
  assign bus.alarm_critical = alarm_q;

endmodule
